// File: rtl/conv_pkg.sv
// conv_pkg: shared mode encodings, fixed 3x3 kernels and the accumulator
// width helper used by the conv3x3 engine and its MAC.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_EDGE_THRESH = 2'd0,
        MODE_SOBEL_MAG   = 2'd1,
        MODE_GAUSS_BLUR  = 2'd2,
        MODE_USER_KERNEL = 2'd3
    } conv_mode_e;

    localparam int TAPS       = 9;
    localparam int CENTRE_TAP = 4;
    localparam int BLUR_SHIFT = 4;

    // Kernels are row-major, tap 0 = top-left, matching the window packing.
    localparam int SOBEL_X_KERNEL [TAPS] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    localparam int SOBEL_Y_KERNEL [TAPS] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
    localparam int GAUSS_KERNEL   [TAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    // Signed product/sum width: unsigned pixel x signed coefficient fits in
    // dw+kw bits, and nine such terms need four more bits of headroom.
    function automatic int acc_width(input int dw, input int kw);
        return dw + kw + 4;
    endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 9-tap signed multiply-accumulate with a registered product
// stage followed by a registered sum stage. Both stages hold when i_en = 0.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int DW = 12,
    parameter int KW = 8,
    parameter int AW = acc_width(DW, KW)
) (
    input  logic                   i_clk,
    input  logic                   i_en,
    input  logic [TAPS*DW-1:0]     i_pix,
    input  logic [TAPS*KW-1:0]     i_coef,
    output logic signed [AW-1:0]   o_sum
);

    logic signed [AW-1:0] prod_d [TAPS];
    logic signed [AW-1:0] prod_q [TAPS];
    logic signed [AW-1:0] sum_d;

    // Form the nine signed products; pixels gain a zero sign bit first.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = AW'($signed({1'b0, i_pix[k*DW +: DW]})) *
                        AW'($signed(i_coef[k*KW +: KW]));
        end
    end

    // Add the registered products into one accumulator-width sum.
    // NOTE: blocking '=' is right here: the running sum is a combinational chain, not state.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_d = sum_d + prod_q[k];
        end
    end

    // Multiply stage then sum stage, frozen together while the pipe stalls.
    // NOTE: datapath registers have no reset; the engine's valid flags decide whether they mean anything.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= prod_d[k];
            end
            o_sum <= sum_d;
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: four-stage 3x3 window engine (multiply, sum, square/abs,
// select/threshold) with valid/ready flow control on both sides.
// Optional feature macro: CONV3X3_USER_KERNEL_EN adds a writable 9-tap
// coefficient bank for mode 3; without it mode 3 passes the centre pixel.
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter int DW = 12,
    parameter int KW = 8,
    parameter int TW = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [1:0]           i_mode,
    input  logic [TW-1:0]        i_thresh,
    input  logic [TAPS*DW-1:0]   i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [DW-1:0]        o_data,
    output logic                 o_valid,
`ifdef CONV3X3_USER_KERNEL_EN
    input  logic                 i_coef_we,
    input  logic [3:0]           i_coef_addr,
    input  logic [KW-1:0]        i_coef_data,
`endif
    input  logic                 i_ready
);

    localparam int AW    = acc_width(DW, KW);
    localparam int ABS_W = AW + 1;
    localparam int SQ_W  = 2 * (DW + 4);
    localparam int CMP_W = (TW > SQ_W) ? TW : SQ_W;
    localparam logic [DW-1:0] PIX_MAX = '1;

    logic advance;

    // Every stage moves together; the only back-pressure point is the output.
    assign o_ready = !o_valid || i_ready;
    assign advance = o_ready;

    // ---------------- fixed kernels -------------------------------------
    logic [TAPS*KW-1:0] sobel_x_coef;
    logic [TAPS*KW-1:0] sobel_y_coef;
    logic [TAPS*KW-1:0] gauss_coef;

    for (genvar k = 0; k < TAPS; k++) begin : g_kernel
        assign sobel_x_coef[k*KW +: KW] = KW'(SOBEL_X_KERNEL[k]);
        assign sobel_y_coef[k*KW +: KW] = KW'(SOBEL_Y_KERNEL[k]);
        assign gauss_coef[k*KW +: KW]   = KW'(GAUSS_KERNEL[k]);
    end

    // ---------------- stages 1-2: MACs ----------------------------------
    logic signed [AW-1:0] gx_sum;
    logic signed [AW-1:0] gy_sum;
    logic signed [AW-1:0] gauss_sum;

    conv3x3_mac #(.DW(DW), .KW(KW), .AW(AW)) u_mac_gx (
        .i_clk  (i_clk),
        .i_en   (advance),
        .i_pix  (i_data),
        .i_coef (sobel_x_coef),
        .o_sum  (gx_sum)
    );

    conv3x3_mac #(.DW(DW), .KW(KW), .AW(AW)) u_mac_gy (
        .i_clk  (i_clk),
        .i_en   (advance),
        .i_pix  (i_data),
        .i_coef (sobel_y_coef),
        .o_sum  (gy_sum)
    );

    conv3x3_mac #(.DW(DW), .KW(KW), .AW(AW)) u_mac_gauss (
        .i_clk  (i_clk),
        .i_en   (advance),
        .i_pix  (i_data),
        .i_coef (gauss_coef),
        .o_sum  (gauss_sum)
    );

    logic [DW-1:0] user_d;

`ifdef CONV3X3_USER_KERNEL_EN
    localparam logic signed [AW-1:0] PIX_MAX_S = AW'(PIX_MAX);

    logic [KW-1:0]        user_coef [TAPS];
    logic [TAPS*KW-1:0]   user_coef_flat;
    logic signed [AW-1:0] user_sum;

    // Coefficient bank writes; addresses past the last tap are dropped.
    // NOTE: the bank is a handful of flops, so it takes the async reset and comes up as all zeros.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < TAPS; k++) begin
                user_coef[k] <= '0;
            end
        end else if (i_coef_we && (i_coef_addr <= 4'(TAPS - 1))) begin
            user_coef[i_coef_addr] <= i_coef_data;
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_user_coef
        assign user_coef_flat[k*KW +: KW] = user_coef[k];
    end

    conv3x3_mac #(.DW(DW), .KW(KW), .AW(AW)) u_mac_user (
        .i_clk  (i_clk),
        .i_en   (advance),
        .i_pix  (i_data),
        .i_coef (user_coef_flat),
        .o_sum  (user_sum)
    );

    // Clamp the user-kernel sum into the pixel range.
    always_comb begin
        user_d = DW'(user_sum);
        if (user_sum < 0) begin
            user_d = '0;
        end else if (user_sum > PIX_MAX_S) begin
            user_d = PIX_MAX;
        end
    end
`else
    logic [DW-1:0] s1_centre;
    logic [DW-1:0] s2_centre;

    // Carry the centre pixel alongside the MAC stages for pass-through mode.
    always_ff @(posedge i_clk) begin
        if (advance) begin
            s1_centre <= i_data[CENTRE_TAP*DW +: DW];
            s2_centre <= s1_centre;
        end
    end

    assign user_d = s2_centre;
`endif

    // ---------------- control and sideband ------------------------------
    logic          s1_valid, s2_valid, s3_valid;
    conv_mode_e    s1_mode, s2_mode, s3_mode;
    logic [TW-1:0] s1_thresh, s2_thresh, s3_thresh;

    // Per-stage valid flags: cleared at once by reset, shifted when advancing.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= i_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Mode and threshold ride with their window through the pipe.
    always_ff @(posedge i_clk) begin
        if (advance) begin
            s1_mode   <= conv_mode_e'(i_mode);
            s2_mode   <= s1_mode;
            s3_mode   <= s2_mode;
            s1_thresh <= i_thresh;
            s2_thresh <= s1_thresh;
            s3_thresh <= s2_thresh;
        end
    end

    // ---------------- stage 3: square / abs -----------------------------
    logic [AW-1:0]    gx_abs, gy_abs;
    logic [ABS_W-1:0] abs_sum;
    logic [SQ_W-1:0]  mag2_d;
    logic [DW-1:0]    mag_d, blur_d;

    logic [SQ_W-1:0]  s3_mag2;
    logic [DW-1:0]    s3_mag, s3_blur, s3_user;

    // Squared gradient magnitude, saturated L1 magnitude and blur average.
    always_comb begin
        gx_abs  = gx_sum[AW-1] ? -gx_sum : gx_sum;
        gy_abs  = gy_sum[AW-1] ? -gy_sum : gy_sum;
        mag2_d  = SQ_W'(gx_abs) * SQ_W'(gx_abs) + SQ_W'(gy_abs) * SQ_W'(gy_abs);
        abs_sum = ABS_W'(gx_abs) + ABS_W'(gy_abs);
        mag_d   = (abs_sum > ABS_W'(PIX_MAX)) ? PIX_MAX : DW'(abs_sum);
        blur_d  = DW'(gauss_sum >>> BLUR_SHIFT);
    end

    // Register the per-mode candidates.
    always_ff @(posedge i_clk) begin
        if (advance) begin
            s3_mag2 <= mag2_d;
            s3_mag  <= mag_d;
            s3_blur <= blur_d;
            s3_user <= user_d;
        end
    end

    // ---------------- stage 4: select / threshold -----------------------
    logic [DW-1:0] result_d;

    // Pick the result for this window's mode; edge test is strict and unsigned.
    always_comb begin
        result_d = s3_user;
        case (s3_mode)
            MODE_EDGE_THRESH: result_d = (CMP_W'(s3_mag2) > CMP_W'(s3_thresh)) ? PIX_MAX : '0;
            MODE_SOBEL_MAG:   result_d = s3_mag;
            MODE_GAUSS_BLUR:  result_d = s3_blur;
            default:          result_d = s3_user;
        endcase
    end

    // Output register; holds its value while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (advance) begin
            o_valid <= s3_valid;
            o_data  <= result_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: directed plus randomized stimulus for conv3x3_engine,
// scored against an arithmetic reference model and an expected-result queue.
// Build with CONV3X3_USER_KERNEL_EN defined to exercise the coefficient bank.
module tb_conv3x3_engine;

    localparam int DW   = 12;
    localparam int KW   = 8;
    localparam int TW   = 32;
    localparam int MAXV = (1 << DW) - 1;
    localparam int LAT  = 4;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic [1:0]        i_mode;
    logic [TW-1:0]     i_thresh;
    logic [9*DW-1:0]   i_data;
    logic              i_valid;
    logic              o_ready;
    logic [DW-1:0]     o_data;
    logic              o_valid;
    logic              i_ready;
`ifdef CONV3X3_USER_KERNEL_EN
    logic              i_coef_we;
    logic [3:0]        i_coef_addr;
    logic [KW-1:0]     i_coef_data;
    logic              cw_we;
    logic [3:0]        cw_addr;
    logic [KW-1:0]     cw_data;
    int                coef_m [9];
`endif

    always #5 i_clk = ~i_clk;

    conv3x3_engine #(.DW(DW), .KW(KW), .TW(TW)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_mode      (i_mode),
        .i_thresh    (i_thresh),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
`ifdef CONV3X3_USER_KERNEL_EN
        .i_coef_we   (i_coef_we),
        .i_coef_addr (i_coef_addr),
        .i_coef_data (i_coef_data),
`endif
        .i_ready     (i_ready)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   lat_chk  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: straight arithmetic on the nine pixels.
    function automatic logic [DW-1:0] model(input logic [1:0] mode, input logic [TW-1:0] thr,
                                           input logic [9*DW-1:0] win);
        longint p [9];
        longint gx, gy, s;
        for (int k = 0; k < 9; k++) p[k] = longint'(win[k*DW +: DW]);
        gx = p[0] - p[2] + 2*p[3] - 2*p[5] + p[6] - p[8];
        gy = p[0] + 2*p[1] + p[2] - p[6] - 2*p[7] - p[8];
        case (mode)
            2'd0: return (gx*gx + gy*gy > longint'(thr)) ? DW'(MAXV) : DW'(0);
            2'd1: begin
                s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                return (s > MAXV) ? DW'(MAXV) : DW'(s);
            end
            2'd2: return DW'((p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5]
                              + p[6] + 2*p[7] + p[8]) >> 4);
            default: begin
`ifdef CONV3X3_USER_KERNEL_EN
                s = 0;
                for (int k = 0; k < 9; k++) s += p[k] * longint'(coef_m[k]);
                if (s < 0) s = 0;
                if (s > MAXV) s = MAXV;
                return DW'(s);
`else
                return DW'(p[4]);
`endif
            end
        endcase
    endfunction

    function automatic logic [9*DW-1:0] rand_win();
        logic [9*DW-1:0] w;
        for (int k = 0; k < 9; k++) begin
            case ($urandom_range(0, 3))
                0:       w[k*DW +: DW] = '0;
                1:       w[k*DW +: DW] = DW'(MAXV);
                default: w[k*DW +: DW] = DW'($urandom_range(0, MAXV));
            endcase
        end
        return w;
    endfunction

    function automatic logic [9*DW-1:0] left_col(input int v);
        logic [9*DW-1:0] w = '0;
        w[0*DW +: DW] = DW'(v);
        w[3*DW +: DW] = DW'(v);
        w[6*DW +: DW] = DW'(v);
        return w;
    endfunction

    // One clock: drive at the falling edge, score what the next rising edge will do.
    task automatic cycle(input logic v, input logic [1:0] m, input logic [TW-1:0] thr,
                         input logic [9*DW-1:0] d, input logic rdy, output logic acc);
        exp_t e;
        @(negedge i_clk);
        i_valid  = v;
        i_mode   = m;
        i_thresh = thr;
        i_data   = d;
        i_ready  = rdy;
`ifdef CONV3X3_USER_KERNEL_EN
        i_coef_we   = cw_we;
        i_coef_addr = cw_addr;
        i_coef_data = cw_data;
`endif
        #1;
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", o_valid, 1'b0);
            end else if (rdy) begin
                e = exp_q.pop_front();
                check("result", o_data, e.data);
                if (lat_chk) check("latency", cyc - e.acc_cyc, LAT);
            end else begin
                check("held_data", o_data, exp_q[0].data);
                check("stall_ready", o_ready, 1'b0);
            end
        end
        acc = v && o_ready;
        if (acc) exp_q.push_back('{data: model(m, thr, d), acc_cyc: cyc});
`ifdef CONV3X3_USER_KERNEL_EN
        if (cw_we && cw_addr <= 4'd8) coef_m[cw_addr] = int'($signed(cw_data));
`endif
        cyc++;
    endtask

    task automatic send(input logic [1:0] m, input logic [TW-1:0] thr, input logic [9*DW-1:0] d);
        logic acc;
        cycle(1'b1, m, thr, d, 1'b1, acc);
        check("accepted", acc, 1'b1);
    endtask

    task automatic drain(input int max_cyc);
        logic acc;
        for (int i = 0; i < max_cyc && exp_q.size() > 0; i++) cycle(1'b0, 2'd0, '0, '0, 1'b1, acc);
        check("drain_empty", exp_q.size(), 0);
        repeat (2) cycle(1'b0, 2'd0, '0, '0, 1'b1, acc);
    endtask

    task automatic reset_now();
        @(negedge i_clk);
        i_rstn  = 1'b0;
        i_valid = 1'b0;
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, '0);
        check("rst_ready", o_ready, 1'b1);
        exp_q.delete();
`ifdef CONV3X3_USER_KERNEL_EN
        for (int k = 0; k < 9; k++) coef_m[k] = 0;
`endif
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    initial begin
        logic            acc;
        logic [1:0]      cm;
        logic [TW-1:0]   ct;
        logic [9*DW-1:0] cd;
        int              sent;
        int              c;

        i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_mode = '0; i_thresh = '0; i_data = '0;
`ifdef CONV3X3_USER_KERNEL_EN
        i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0;
        cw_we = 1'b0; cw_addr = '0; cw_data = '0;
`endif
        reset_now();

        // Directed windows, unstalled, with exact latency checks.
        lat_chk = 1'b1;
        send(2'd0, 32'd0, {9{12'd100}});
        drain(10);
        send(2'd0, 32'd1000, left_col(4095));
        send(2'd0, 32'd268304400, left_col(4095));
        send(2'd0, 32'd268304399, left_col(4095));
        send(2'd1, 32'd0, left_col(4095));
        send(2'd2, 32'd0, {9{12'd160}});
        send(2'd0, 32'd1000, left_col(4095));
        send(2'd2, 32'd1000, {9{12'd160}});
        drain(10);

        // User kernel / centre pass-through.
`ifdef CONV3X3_USER_KERNEL_EN
        cw_we = 1'b1; cw_addr = 4'd4; cw_data = 8'd1;
        cycle(1'b0, 2'd0, '0, '0, 1'b1, acc);
        cw_addr = 4'd12; cw_data = 8'd5;
        cycle(1'b0, 2'd0, '0, '0, 1'b1, acc);
        cw_we = 1'b0;
`endif
        cd = '0;
        cd[4*DW +: DW] = 12'd77;
        send(2'd3, 32'd0, cd);
        send(2'd3, 32'd0, rand_win());
        drain(10);

        // Eight windows with output stalled on stream cycles 5-7.
        lat_chk = 1'b0;
        sent = 0;
        c    = 0;
        cm = 2'($urandom_range(0, 3)); ct = $urandom % 32'd400000000; cd = rand_win();
        while (sent < 8 && c < 100) begin
            cycle(1'b1, cm, ct, cd, !(c >= 5 && c <= 7), acc);
            if (acc) begin
                sent++;
                cm = 2'($urandom_range(0, 3)); ct = $urandom % 32'd400000000; cd = rand_win();
            end
            c++;
        end
        check("stream_sent", sent, 8);
        drain(20);

        // Reset with three windows in flight, the oldest already at the output.
        lat_chk = 1'b1;
        send(2'd1, '0, rand_win());
        send(2'd2, '0, rand_win());
        send(2'd0, '0, rand_win());
        cycle(1'b0, 2'd0, '0, '0, 1'b0, acc);
        reset_now();
        send(2'd2, '0, {9{12'd160}});
        drain(10);

        // Random traffic on both handshakes.
        lat_chk = 1'b0;
        for (int i = 0; i < 400; i++) begin
`ifdef CONV3X3_USER_KERNEL_EN
            cw_we   = ($urandom_range(0, 3) == 0);
            cw_addr = 4'($urandom_range(0, 15));
            cw_data = KW'($urandom);
`endif
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom % 32'd400000000,
                  rand_win(), $urandom_range(0, 3) != 0, acc);
        end
`ifdef CONV3X3_USER_KERNEL_EN
        cw_we = 1'b0;
`endif
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
